dmem_arbiter: RTL and testbench

Two-port arbiter sharing the single data memory (DataMem: we, addr, data_i, combinational data_o) between the core's load/store path (port 0) and a debug/loader master (port 1). Grants one access per cycle with round-robin fairness, an optional bounded lock for back-to-back bursts, and a registered per-port response. Sits between the EX/ALUOut load/store path and DataMem; the core stalls its PC while its request is pending and ungranted.

---
 rtl/dmem_arb_pkg.sv | 27 ++
 rtl/arb_rr2.sv | 31 +++
 rtl/dmem_arbiter.sv | 151 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arb_pkg
// Purpose  : Shared types and constants for the data-memory arbiter.
//            Arbiter state encoding, port index constants and default widths.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

  // Arbiter ownership state
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Port indices into the grant/request vectors
  localparam int P_CORE = 0;
  localparam int P_DBG  = 1;

  // Default widths
  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_MAX_LOCK = 8;

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/arb_rr2.sv
`default_nettype none
// ============================================================================
// Module   : arb_rr2
// Purpose  : Two-way round-robin pick. A lone requester always wins; on a
//            tie the port that was NOT granted last wins.
// Ports    : i_req  [1:0] request vector (bit P_CORE / P_DBG)
//            i_last       index of the port granted most recently
//            o_gnt  [1:0] one-hot (or zero) grant
// Revision : 1.0 - initial release
// ============================================================================
module arb_rr2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    if (i_req == 2'b11) begin
      if (i_last) o_gnt[P_CORE] = 1'b1;
      else        o_gnt[P_DBG]  = 1'b1;
    end else begin
      // Zero or one requester: the request vector is already the grant.
      o_gnt = i_req;
    end
  end

endmodule : arb_rr2
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares one combinational-read data memory between the core
//            load/store path (port 0) and a debug/loader master (port 1).
//            One access per cycle, round-robin fairness, bounded lock for
//            bursts, registered per-port response one cycle after grant.
// Ports    : clk, rst (async, active-low)
//            reqN_i/weN_i/lockN_i/addrN_i/wdataN_i   request side, N = 0,1
//            gntN_o (combinational), rvalidN_o/rdataN_o (registered)
//            stall0_o                                 core PC hold
//            mem_we_o/mem_addr_o/mem_wdata_o/mem_rdata_i  DataMem side
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_LOCK = DEF_MAX_LOCK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_i,
  input  logic              we0_i,
  input  logic              lock0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic              req1_i,
  input  logic              we1_i,
  input  logic              lock1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              rvalid0_o,
  output logic              rvalid1_o,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic              stall0_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int CNT_W = $clog2(MAX_LOCK);
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(MAX_LOCK - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  arb_state_t       r_state, w_state_nxt;
  logic             r_last, w_last_nxt;
  logic [CNT_W-1:0] r_lock_cnt, w_lock_cnt_nxt;
  logic [1:0]       w_rr_gnt;
  logic [1:0]       w_gnt;
  logic             w_we;
  logic [CNT_W-1:0] w_cnt0, w_cnt1;

  arb_rr2 u_rr (
    .i_req  ({req1_i, req0_i}),
    .i_last (r_last),
    .o_gnt  (w_rr_gnt)
  );

  // Grant: a held lock overrides round-robin; a dropped lock falls through
  // to normal arbitration in the same cycle.
  always_comb begin
    w_gnt = w_rr_gnt;
    if (r_state == OWN0 && req0_i)      w_gnt = 2'b01;
    else if (r_state == OWN1 && req1_i) w_gnt = 2'b10;
  end

  // The running count belongs only to the current owner; a port taking the
  // bus fresh starts its own burst from zero.
  assign w_cnt0 = (r_state == OWN0) ? r_lock_cnt : '0;
  assign w_cnt1 = (r_state == OWN1) ? r_lock_cnt : '0;

  always_comb begin
    w_state_nxt    = IDLE;
    w_lock_cnt_nxt = '0;
    w_last_nxt     = r_last;
    if (w_gnt[P_CORE]) begin
      w_last_nxt = 1'b0;
      if (lock0_i && w_cnt0 < C_CNT_MAX) begin
        w_state_nxt    = OWN0;
        w_lock_cnt_nxt = (r_state == OWN0) ? r_lock_cnt + C_CNT_ONE : C_CNT_ONE;
      end
    end else if (w_gnt[P_DBG]) begin
      w_last_nxt = 1'b1;
      if (lock1_i && w_cnt1 < C_CNT_MAX) begin
        w_state_nxt    = OWN1;
        w_lock_cnt_nxt = (r_state == OWN1) ? r_lock_cnt + C_CNT_ONE : C_CNT_ONE;
      end
    end
  end

  // Memory-side mux; idle bus drives zeros.
  always_comb begin
    w_we        = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (w_gnt[P_CORE]) begin
      w_we        = we0_i;
      mem_addr_o  = addr0_i;
      mem_wdata_o = wdata0_i;
    end else if (w_gnt[P_DBG]) begin
      w_we        = we1_i;
      mem_addr_o  = addr1_i;
      mem_wdata_o = wdata1_i;
    end
  end

  // Write enable is gated by reset so no store reaches memory while held.
  assign mem_we_o = w_we & rst;
  assign gnt0_o   = w_gnt[P_CORE];
  assign gnt1_o   = w_gnt[P_DBG];
  assign stall0_o = req0_i & ~w_gnt[P_CORE];

  // last=1 out of reset so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_last     <= 1'b1;
      r_lock_cnt <= '0;
      rvalid0_o  <= 1'b0;
      rvalid1_o  <= 1'b0;
      rdata0_o   <= '0;
      rdata1_o   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_last     <= w_last_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      rvalid0_o  <= w_gnt[P_CORE];
      rvalid1_o  <= w_gnt[P_DBG];
      if (w_gnt[P_CORE] && !we0_i) rdata0_o <= mem_rdata_i;
      if (w_gnt[P_DBG]  && !we1_i) rdata1_o <= mem_rdata_i;
    end
  end

`ifndef SYNTHESIS
  // A pending, ungranted request must not change until it is granted.
  a_hold0 : assert property (@(posedge clk) disable iff (!rst)
    (req0_i && !gnt0_o) |=> (req0_i && we0_i == $past(we0_i) &&
      addr0_i == $past(addr0_i) && wdata0_i == $past(wdata0_i)));
  a_hold1 : assert property (@(posedge clk) disable iff (!rst)
    (req1_i && !gnt1_o) |=> (req1_i && we1_i == $past(we1_i) &&
      addr1_i == $past(addr1_i) && wdata1_i == $past(wdata1_i)));
`endif

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed self-checking bench for dmem_arbiter with a small
//            word-addressed memory model behind the memory port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_i, we0_i, lock0_i, req1_i, we1_i, lock1_i;
  logic [31:0] addr0_i, wdata0_i, addr1_i, wdata1_i;
  logic        gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, stall0_o, mem_we_o;
  logic [31:0] rdata0_o, rdata1_o, mem_addr_o, mem_wdata_o, mem_rdata_i;

  logic [31:0] mem [0:63];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mem_rdata_i = mem[mem_addr_o[7:2]];
  always @(posedge clk) if (mem_we_o) mem[mem_addr_o[7:2]] <= mem_wdata_o;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOCK(8)) dut (
    .clk(clk), .rst(rst),
    .req0_i(req0_i), .we0_i(we0_i), .lock0_i(lock0_i), .addr0_i(addr0_i), .wdata0_i(wdata0_i),
    .req1_i(req1_i), .we1_i(we1_i), .lock1_i(lock1_i), .addr1_i(addr1_i), .wdata1_i(wdata1_i),
    .gnt0_o(gnt0_o), .gnt1_o(gnt1_o), .rvalid0_o(rvalid0_o), .rvalid1_o(rvalid1_o),
    .rdata0_o(rdata0_o), .rdata1_o(rdata1_o), .stall0_o(stall0_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] <= 32'h1000 + i;
    mem[4] <= 32'hDEADBEEF;
  end

  initial begin
    rst = 1'b0;
    req0_i = 0; we0_i = 0; lock0_i = 0; addr0_i = 0; wdata0_i = 0;
    req1_i = 0; we1_i = 0; lock1_i = 0; addr1_i = 0; wdata1_i = 0;
    #1;
    chk("rst_rvalid0", {31'd0, rvalid0_o}, 0);
    chk("rst_rvalid1", {31'd0, rvalid1_o}, 0);
    chk("rst_rdata0", rdata0_o, 0);
    chk("rst_rdata1", rdata1_o, 0);
    chk("rst_memwe", {31'd0, mem_we_o}, 0);
    tick(); tick();
    rst = 1'b1;

    // Single read on port 1
    req1_i = 1; addr1_i = 32'h10; #1;
    chk("rd1_gnt1", {31'd0, gnt1_o}, 1);
    chk("rd1_gnt0", {31'd0, gnt0_o}, 0);
    chk("rd1_addr", mem_addr_o, 32'h10);
    tick(); req1_i = 0;
    chk("rd1_rvalid1", {31'd0, rvalid1_o}, 1);
    chk("rd1_rdata1", rdata1_o, 32'hDEADBEEF);
    chk("rd1_rvalid0", {31'd0, rvalid0_o}, 0);

    // Contention: 0,1,0,1 then port 0 alone
    req0_i = 1; addr0_i = 32'h00; req1_i = 1; addr1_i = 32'h04; #1;
    chk("cont_c1_gnt0", {31'd0, gnt0_o}, 1);
    chk("cont_c1_stall", {31'd0, stall0_o}, 0);
    tick();
    chk("cont_c1_rdata0", rdata0_o, 32'h1000);
    chk("cont_c2_gnt1", {31'd0, gnt1_o}, 1);
    chk("cont_c2_stall", {31'd0, stall0_o}, 1);
    tick();
    chk("cont_c2_rdata1", rdata1_o, 32'h1001);
    chk("cont_c3_gnt0", {31'd0, gnt0_o}, 1);
    chk("cont_c3_stall", {31'd0, stall0_o}, 0);
    tick();
    chk("cont_c4_gnt1", {31'd0, gnt1_o}, 1);
    chk("cont_c4_stall", {31'd0, stall0_o}, 1);
    tick(); req1_i = 0; #1;
    chk("cont_c5_gnt0", {31'd0, gnt0_o}, 1);
    tick(); req0_i = 0;
    chk("cont_c5_rvalid0", {31'd0, rvalid0_o}, 1);

    // Write then read back
    req0_i = 1; we0_i = 1; addr0_i = 32'h20; wdata0_i = 32'h1234; #1;
    chk("wr_memwe", {31'd0, mem_we_o}, 1);
    chk("wr_addr", mem_addr_o, 32'h20);
    chk("wr_wdata", mem_wdata_o, 32'h1234);
    tick();
    chk("wr_rvalid0", {31'd0, rvalid0_o}, 1);
    chk("wr_rdata0_hold", rdata0_o, 32'h1000);
    req0_i = 0; we0_i = 0; wdata0_i = 0; req1_i = 1; addr1_i = 32'h20; #1;
    chk("rb_gnt1", {31'd0, gnt1_o}, 1);
    chk("rb_memwe", {31'd0, mem_we_o}, 0);
    tick(); req1_i = 0;
    chk("rb_rdata1", rdata1_o, 32'h1234);
    #1;
    chk("idle_addr", mem_addr_o, 0);
    chk("idle_wdata", mem_wdata_o, 0);
    chk("idle_gnt", {30'd0, gnt1_o, gnt0_o}, 0);

    // Lock cap: port 0 read to make last=0, then port 1 locked burst
    req0_i = 1; addr0_i = 32'h0C; tick();
    chk("pre_rdata0", rdata0_o, 32'h1003);
    addr0_i = 32'h08; req1_i = 1; we1_i = 1; lock1_i = 1;
    for (int i = 0; i < 8; i++) begin
      addr1_i = 32'h40 + 4 * i; wdata1_i = 32'hA0 + i; #1;
      chk($sformatf("lock_g%0d_gnt1", i), {31'd0, gnt1_o}, 1);
      chk($sformatf("lock_g%0d_stall", i), {31'd0, stall0_o}, 1);
      tick();
    end
    addr1_i = 32'h60; wdata1_i = 32'hA8; #1;
    chk("lockcap_gnt0", {31'd0, gnt0_o}, 1);
    chk("lockcap_gnt1", {31'd0, gnt1_o}, 0);
    tick(); req0_i = 0;
    chk("lockcap_rdata0", rdata0_o, 32'h1002);
    for (int j = 8; j < 12; j++) begin
      addr1_i = 32'h40 + 4 * j; wdata1_i = 32'hA0 + j; #1;
      chk($sformatf("resume_g%0d_gnt1", j), {31'd0, gnt1_o}, 1);
      tick();
    end
    req1_i = 0; we1_i = 0; lock1_i = 0;
    chk("burst_mem7", mem[23], 32'hA7);
    chk("burst_mem11", mem[27], 32'hAB);
    chk("burst_rdata1_hold", rdata1_o, 32'h1234);

    // Lock honoured, then released
    req0_i = 1; lock0_i = 1; addr0_i = 32'h14; tick();
    chk("own0_rdata0", rdata0_o, 32'h1005);
    req1_i = 1; addr1_i = 32'h18; #1;
    chk("own0_gnt0", {31'd0, gnt0_o}, 1);
    chk("own0_gnt1", {31'd0, gnt1_o}, 0);
    tick(); req0_i = 0; lock0_i = 0; #1;
    chk("release_gnt1", {31'd0, gnt1_o}, 1);
    tick(); req1_i = 0;
    chk("release_rdata1", rdata1_o, 32'h1006);

    // Reset mid-burst
    req0_i = 1; lock0_i = 1; we0_i = 1; addr0_i = 32'h30; wdata0_i = 32'h55; #1;
    chk("mb_memwe", {31'd0, mem_we_o}, 1);
    tick();
    rst = 1'b0; #1;
    chk("mb_rvalid0", {31'd0, rvalid0_o}, 0);
    chk("mb_rdata0", rdata0_o, 0);
    chk("mb_rdata1", rdata1_o, 0);
    chk("mb_memwe_forced", {31'd0, mem_we_o}, 0);
    chk("mb_gnt0_comb", {31'd0, gnt0_o}, 1);
    tick();
    chk("mb_rvalid0_held", {31'd0, rvalid0_o}, 0);
    rst = 1'b1;
    lock0_i = 0; we0_i = 0; wdata0_i = 0; addr0_i = 32'h00;
    req1_i = 1; addr1_i = 32'h04; #1;
    chk("postrst_gnt0", {31'd0, gnt0_o}, 1);
    chk("postrst_gnt1", {31'd0, gnt1_o}, 0);
    tick(); req0_i = 0;
    chk("postrst_rdata0", rdata0_o, 32'h1000);
    #1;
    chk("postrst_next_gnt1", {31'd0, gnt1_o}, 1);
    tick(); req1_i = 0;
    chk("postrst_rdata1", rdata1_o, 32'h1001);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_dmem_arbiter
`default_nettype wire
